// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with valid/ready, optional skid, stall, flush and NOP bubbles
module pipe_stage_reg #(
   parameter int                 DATA_W     = 64,
   parameter bit                 SKID_EN    = 1'b1,
   parameter bit                 BUBBLE_NOP = 1'b1,
   parameter logic [DATA_W-1:0]  NOP_VAL    = '0,
   parameter logic [DATA_W-1:0]  RESET_VAL  = '0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              stall,
   input  logic              flush
);
   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
   state_t            state, state_nxt;
   logic [DATA_W-1:0] main_q, main_nxt, skid_q, skid_nxt;
   logic              rdy_q, in_fire, out_fire;
   assign out_valid = state != EMPTY;
   assign out_data  = main_q;
   assign out_fire  = out_valid & out_ready & ~stall;
   assign in_fire   = in_valid & in_ready;
   // with a skid entry in_ready comes from a flop; without it, it looks through to out_ready
   assign in_ready  = SKID_EN ? rdy_q & ~stall : ~clr & ~stall & (~out_valid | out_ready);
   // next state and payload: flush beats stall, stall beats handshakes
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      if (flush) begin
         state_nxt = EMPTY;
         main_nxt  = BUBBLE_NOP ? NOP_VAL : main_q;
         skid_nxt  = BUBBLE_NOP ? NOP_VAL : skid_q;
      end else if (!stall) begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nxt = FULL;
                  main_nxt  = in_data;
               end
            end
            FULL: begin
               if (in_fire && out_fire) begin
                  main_nxt = in_data;
               end else if (in_fire && SKID_EN) begin
                  state_nxt = SKID;
                  skid_nxt  = in_data;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
                  main_nxt  = BUBBLE_NOP ? NOP_VAL : main_q;
               end
            end
            SKID: begin
               if (out_fire) begin
                  state_nxt = FULL;
                  main_nxt  = skid_q;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end
   // state, payload and registered ready, all cleared asynchronously
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= EMPTY;
         main_q <= RESET_VAL;
         skid_q <= RESET_VAL;
         rdy_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
         rdy_q  <= state_nxt != SKID;
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for the skid and non-skid variants of pipe_stage_reg
module tb_pipe_stage_reg;
   logic        clk = 1'b0, clr = 1'b1;
   logic        in_valid, in_ready, out_valid, out_ready, stall, flush;
   logic [63:0] in_data, out_data;
   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, stall_b, flush_b;
   logic [63:0] in_data_b, out_data_b;
   logic [63:0] sb[$], sb_b[$];
   int          checks = 0, errors = 0;
   localparam logic [63:0] A = 64'h4_1, B = 64'h8_2, C = 64'hC_3, R = 64'h00400004_8C010000;
   always #5 clk = ~clk;
   pipe_stage_reg #(.SKID_EN(1'b1)) dut (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .stall(stall), .flush(flush)
   );
   pipe_stage_reg #(.SKID_EN(1'b0)) dut_b (
      .clk(clk), .clr(clr), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .stall(stall_b), .flush(flush_b)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   // scoreboards: handshakes observed mid-cycle, ahead of the edge that acts on them
   always @(negedge clk) begin
      if (clr || flush) sb.delete();
      else begin
         if (out_valid && out_ready && !stall) begin
            if (sb.size() == 0) check("sb_underflow", out_data, 64'hx);
            else check("sb_data", out_data, sb.pop_front());
         end
         if (in_valid && in_ready) sb.push_back(in_data);
      end
   end
   always @(negedge clk) begin
      if (clr || flush_b) sb_b.delete();
      else begin
         if (out_valid_b && out_ready_b && !stall_b) begin
            if (sb_b.size() == 0) check("sb_b_underflow", out_data_b, 64'hx);
            else check("sb_b_data", out_data_b, sb_b.pop_front());
         end
         if (in_valid_b && in_ready_b) sb_b.push_back(in_data_b);
      end
   end
   initial begin
      in_valid = 0; out_ready = 0; stall = 0; flush = 0; in_data = '0;
      in_valid_b = 0; out_ready_b = 0; stall_b = 0; flush_b = 0; in_data_b = '0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_in_ready_b", 64'(in_ready_b), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      step(2);
      clr = 0;
      step(1);
      check("rel_in_ready", 64'(in_ready), 64'd1);
      check("rel_in_ready_b", 64'(in_ready_b), 64'd1);
      // streaming at one beat per cycle
      out_ready = 1; in_valid = 1; in_data = A;
      step(1);
      check("str_a", out_data, A);
      check("str_a_rdy", 64'(in_ready), 64'd1);
      in_data = B;
      step(1);
      check("str_b", out_data, B);
      in_data = C;
      step(1);
      check("str_c", out_data, C);
      check("str_c_rdy", 64'(in_ready), 64'd1);
      in_valid = 0;
      step(1);
      check("str_drain_valid", 64'(out_valid), 64'd0);
      check("str_drain_nop", out_data, 64'd0);
      // skid fill and drain
      out_ready = 0; in_valid = 1; in_data = A;
      step(1);
      check("skid_full_rdy", 64'(in_ready), 64'd1);
      in_data = B;
      step(1);
      check("skid_rdy", 64'(in_ready), 64'd0);
      check("skid_data", out_data, A);
      check("skid_valid", 64'(out_valid), 64'd1);
      in_data = C;
      step(1);
      check("skid_hold_data", out_data, A);
      check("skid_hold_rdy", 64'(in_ready), 64'd0);
      in_valid = 0; out_ready = 1;
      step(1);
      check("skid_drain_b", out_data, B);
      check("skid_drain_rdy", 64'(in_ready), 64'd1);
      step(1);
      check("skid_empty", 64'(out_valid), 64'd0);
      // stall freezes the stage even with downstream ready
      out_ready = 0; in_valid = 1; in_data = A;
      step(1);
      stall = 1; out_ready = 1; in_data = B;
      #1;
      check("stall_rdy_comb", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("stall_data", out_data, A);
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_rdy", 64'(in_ready), 64'd0);
      end
      stall = 0;
      step(1);
      check("stall_rel_b", out_data, B);
      in_valid = 0;
      step(1);
      check("stall_empty", 64'(out_valid), 64'd0);
      // flush from SKID with a beat on the input
      out_ready = 0; in_valid = 1; in_data = A;
      step(1);
      in_data = B;
      step(1);
      check("pre_flush_rdy", 64'(in_ready), 64'd0);
      in_data = C; flush = 1;
      step(1);
      flush = 0; in_valid = 0;
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_nop", out_data, 64'd0);
      check("flush_rdy", 64'(in_ready), 64'd1);
      out_ready = 1;
      step(2);
      check("flush_no_replay", 64'(out_valid), 64'd0);
      // asynchronous clear while FULL
      out_ready = 0; in_valid = 1; in_data = R;
      step(1);
      in_valid = 0;
      check("pre_rst_data", out_data, R);
      #2 clr = 1;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_data", out_data, 64'd0);
      check("arst_rdy", 64'(in_ready), 64'd0);
      #3 clr = 0;
      step(1);
      check("arst_rel_rdy", 64'(in_ready), 64'd1);
      // non-skid variant: ready follows out_ready combinationally
      in_valid_b = 1; in_data_b = A;
      step(1);
      check("b_valid", 64'(out_valid_b), 64'd1);
      check("b_rdy_blocked", 64'(in_ready_b), 64'd0);
      out_ready_b = 1;
      #1;
      check("b_rdy_comb", 64'(in_ready_b), 64'd1);
      in_data_b = B;
      step(1);
      check("b_pass_b", out_data_b, B);
      in_data_b = C;
      step(1);
      check("b_pass_c", out_data_b, C);
      check("b_pass_rdy", 64'(in_ready_b), 64'd1);
      in_valid_b = 0;
      step(1);
      check("b_empty", 64'(out_valid_b), 64'd0);
      step(1);
      check("sb_left", 64'(sb.size()), 64'd0);
      check("sb_b_left", 64'(sb_b.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
